rx_host_sched: RTL and testbench
================================

// Module: rx_host_sched
// PURPOSE
//  Sequencer and arbiter in front of rx_host. Shares the single remote-IO command slot between
//  N_REQ requesters and issues at most one command per link frame, so a pending command is
//  never overwritten before the frame picks it up. Returns read data to the requester that
//  issued the read, and forwards sample-delay configuration writes (rx_host addr 1).
// PARAMETERS
//  N_REQ         4     number of requesters, >=2
//  FRAME         512   link frame length in clocks; guard after each issued write
//  READ_TIMEOUT  1024  clocks to wait for host_rvalid after a read is issued
// PORTS
//  clock          in   1         125 MHz system clock, same clock as rx_host
//  reset_n        in   1         asynchronous, active-low reset
//  req_valid      in   N_REQ     requester i has a command on req_data[i*21+:21]
//  req_data       in   21*N_REQ  [20]=read, [19:16]=remote addr, [15:0]=write data
//  req_ready      out  N_REQ     one-hot; command i accepted this cycle
//  rsp_valid      out  1         one-cycle pulse; read response
//  rsp_id         out  clog2(N_REQ)  index of the requester that issued the read
//  rsp_data       out  16        read data; 0 on timeout
//  rsp_timeout    out  1         qualifies rsp_valid: no host_rvalid within READ_TIMEOUT
//  cfg_valid      in   1         request to set the rx_host sample delay
//  cfg_delay      in   3         sample delay value
//  busy           out  1         state != IDLE or a cfg write is pending
//  host_wvalid    out  1         to rx_host wvalid
//  host_wdata     out  21        to rx_host wdata
//  host_addr      out  1         to rx_host addr: 0 = link command, 1 = sample delay
//  host_rdata     in   64        from rx_host rdata; only [15:0] is used
//  host_rvalid    in   1         from rx_host rvalid
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, rr pointer 0, cfg_pending 0, counter 0.
//  Outputs: all registered except req_ready, which is a combinational function of
//  state, rr pointer, cfg_pending and req_valid.
//  Grant: in IDLE with cfg_pending=0, g is the first i with req_valid[i], searching from the
//  rr pointer upward and wrapping. req_ready[g]=1 that cycle; req_data[g] is captured;
//  rr <= g+1 mod N_REQ.
//  States:
//   IDLE   -> CFG   if cfg_pending (cfg has priority over requesters; no req_ready)
//          -> ISSUE on a grant
//   CFG    : host_wvalid=1, host_addr=1, host_wdata={18'b0,delay}; clear cfg_pending; -> IDLE
//   ISSUE  : host_wvalid=1, host_addr=0, host_wdata=captured command; cnt<=0;
//            -> WAIT_R if bit20 set, else -> WAIT_W
//   WAIT_W : cnt++; when cnt==FRAME-1 -> IDLE (a write occupies exactly FRAME+1 clocks)
//   WAIT_R : if host_rvalid, next cycle rsp_valid=1, rsp_data=host_rdata[15:0],
//            rsp_timeout=0; -> IDLE.
//            Else if cnt==READ_TIMEOUT-1, next cycle rsp_valid=1, rsp_timeout=1,
//            rsp_data=0; -> IDLE.
//            rvalid and timeout in the same cycle: the rvalid wins.
//  Latency: grant to host_wvalid is 1 clock; host_rvalid to rsp_valid is 1 clock.
//  cfg_valid is accepted in any state and sets cfg_pending with that cfg_delay. A new
//  cfg_valid while pending overwrites the value (last write wins). A cfg write issued
//  during CFG is serviced on a later IDLE.
//  A host_rvalid outside WAIT_R (stray or late) is ignored; no response is generated.
//  Reset mid-operation aborts immediately with no response. rx_host has no reset, so an
//  in-flight read may still return; it is dropped as stray.
//  Counter width is clog2(max(FRAME,READ_TIMEOUT))+1 and never wraps.
// STRUCTURE
//  Package rx_host_pkg: state enum {IDLE,CFG,ISSUE,WAIT_W,WAIT_R}; RD_BIT=20;
//  field ranges ADDR=[19:16] and DATA=[15:0]; HOST_ADDR_CMD=0, HOST_ADDR_CFG=1.
//  Sub-module rr_arbiter #(N): req vector + pointer in, one-hot grant + index out; purely
//  combinational; the pointer register lives in rx_host_sched.
// TESTING
//  1. Reset released, idle bus -> all outputs 0, busy=0, no host_wvalid for 2000 clocks.
//  2. req0 write 0x0_3_ABCD -> req_ready[0] at T, host_wvalid/addr0/wdata 0x03ABCD at T+1,
//     next grant no earlier than T+513.
//  3. req0..3 all valid continuously -> grant order 0,1,2,3,0; each one-hot; one per frame.
//  4. req2 read 0x1_5_0000, model returns rvalid with rdata 0x1234 after 478 clocks
//     -> rsp_valid 1 clock later, rsp_id=2, rsp_data=0x1234, rsp_timeout=0.
//  5. Read with no rvalid -> rsp_timeout=1, rsp_data=0 at issue+1025. A late rvalid is then
//     ignored, and no second rsp_valid is produced.
//  6. cfg_valid delay=5 then delay=6 during WAIT_W, with req1 also valid -> after the write
//     guard a single host_wvalid addr1 wdata=6 is issued before req1 is granted.
//     Assert reset_n low mid-WAIT_R -> outputs 0 and no rsp.

Source files
------------

// File: rtl/rx_host_pkg.sv
// Shared types and field positions for the rx_host command sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rx_host_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CFG    = 3'd1,
        ISSUE  = 3'd2,
        WAIT_W = 3'd3,
        WAIT_R = 3'd4
    } state_t;

    // Remote-IO command layout: {read, addr[3:0], data[15:0]}
    localparam int CMD_W   = 21;
    localparam int RD_BIT  = 20;
    localparam int ADDR_HI = 19;
    localparam int ADDR_LO = 16;
    localparam int DATA_HI = 15;
    localparam int DATA_LO = 0;

    localparam logic HOST_ADDR_CMD = 1'b0;
    localparam logic HOST_ADDR_CFG = 1'b1;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first asserted request at or above ptr, wrapping.
// Latency: purely combinational; the pointer register lives in the caller.
// Backpressure: none; the caller decides whether the grant is used.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx,
    output logic          any
);

    // Scan N positions starting at ptr, take the first asserted request
    always_comb begin
        int j;
        j       = 0;
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        for (int k = 0; k < N; k++) begin
            j = (int'(ptr) + k) % N;
            if (!any && req[j]) begin
                any     = 1'b1;
                gnt[j]  = 1'b1;
                gnt_idx = IW'(j);
            end
        end
    end

endmodule

// File: rtl/rx_host_sched.sv
// Arbitrates N_REQ requesters onto the single rx_host command slot, one command per frame.
// Latency: grant -> host_wvalid 1 clock; host_rvalid -> rsp_valid 1 clock.
// Backpressure: req_ready only in IDLE with no cfg pending; cfg writes always accepted (last wins).
module rx_host_sched
    import rx_host_pkg::*;
#(
    parameter int N_REQ        = 4,
    parameter int FRAME        = 512,
    parameter int READ_TIMEOUT = 1024,
    parameter int ID_W         = $clog2(N_REQ)
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [CMD_W*N_REQ-1:0] req_data,
    output logic [N_REQ-1:0]       req_ready,
    output logic                   rsp_valid,
    output logic [ID_W-1:0]        rsp_id,
    output logic [15:0]            rsp_data,
    output logic                   rsp_timeout,
    input  logic                   cfg_valid,
    input  logic [2:0]             cfg_delay,
    output logic                   busy,
    output logic                   host_wvalid,
    output logic [CMD_W-1:0]       host_wdata,
    output logic                   host_addr,
    input  logic [63:0]            host_rdata,
    input  logic                   host_rvalid
);

    localparam int CNT_W = $clog2(max2(FRAME, READ_TIMEOUT)) + 1;

    state_t            state_q, state_d;
    logic [ID_W-1:0]   rr_q, rr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              rd_q, rd_d;
    logic [ID_W-1:0]   cur_id_q, cur_id_d;
    logic              cfg_pending_q, cfg_pending_d;
    logic [2:0]        cfg_delay_q, cfg_delay_d;
    logic              busy_q, busy_d;
    logic              host_wvalid_q, host_wvalid_d;
    logic [CMD_W-1:0]  host_wdata_q, host_wdata_d;
    logic              host_addr_q, host_addr_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
    logic [15:0]       rsp_data_q, rsp_data_d;
    logic              rsp_timeout_q, rsp_timeout_d;

    logic [N_REQ-1:0]  gnt_oh;
    logic [ID_W-1:0]   gnt_idx;
    logic              gnt_any;
    logic [CMD_W-1:0]  gnt_cmd;

    // Upper read-data bits are not part of the response
    logic unused_rdata_hi;
    assign unused_rdata_hi = ^host_rdata[63:16];

    rr_arbiter #(.N(N_REQ), .IW(ID_W)) u_arb (
        .req     (req_valid),
        .ptr     (rr_q),
        .gnt     (gnt_oh),
        .gnt_idx (gnt_idx),
        .any     (gnt_any)
    );

    assign gnt_cmd = req_data[gnt_idx*CMD_W +: CMD_W];

    // Sequencer: grant/cfg selection in IDLE, frame guard, read wait and timeout
    always_comb begin
        state_d       = state_q;
        rr_d          = rr_q;
        cnt_d         = cnt_q;
        rd_d          = rd_q;
        cur_id_d      = cur_id_q;
        cfg_pending_d = cfg_pending_q;
        cfg_delay_d   = cfg_delay_q;
        host_wvalid_d = 1'b0;
        host_wdata_d  = host_wdata_q;
        host_addr_d   = host_addr_q;
        rsp_valid_d   = 1'b0;
        rsp_id_d      = rsp_id_q;
        rsp_data_d    = rsp_data_q;
        rsp_timeout_d = rsp_timeout_q;
        req_ready     = '0;

        case (state_q)
            IDLE: begin
                if (cfg_pending_q) begin
                    // Pending is cleared as the value is captured so a cfg_valid
                    // arriving now or during CFG is kept for a later IDLE.
                    state_d       = CFG;
                    host_wvalid_d = 1'b1;
                    host_addr_d   = HOST_ADDR_CFG;
                    host_wdata_d  = {18'b0, cfg_delay_q};
                    cfg_pending_d = 1'b0;
                end else if (gnt_any) begin
                    req_ready     = gnt_oh;
                    state_d       = ISSUE;
                    host_wvalid_d = 1'b1;
                    host_addr_d   = HOST_ADDR_CMD;
                    host_wdata_d  = gnt_cmd;
                    rd_d          = gnt_cmd[RD_BIT];
                    cur_id_d      = gnt_idx;
                    rr_d          = (gnt_idx == ID_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
                end
            end
            CFG: begin
                state_d = IDLE;
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = rd_q ? WAIT_R : WAIT_W;
            end
            WAIT_W: begin
                if (cnt_q == CNT_W'(FRAME - 1)) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WAIT_R: begin
                // Data beats a same-cycle timeout
                if (host_rvalid) begin
                    rsp_valid_d   = 1'b1;
                    rsp_id_d      = cur_id_q;
                    rsp_data_d    = host_rdata[DATA_HI:DATA_LO];
                    rsp_timeout_d = 1'b0;
                    state_d       = IDLE;
                end else if (cnt_q == CNT_W'(READ_TIMEOUT - 1)) begin
                    rsp_valid_d   = 1'b1;
                    rsp_id_d      = cur_id_q;
                    rsp_data_d    = '0;
                    rsp_timeout_d = 1'b1;
                    state_d       = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (cfg_valid) begin
            cfg_pending_d = 1'b1;
            cfg_delay_d   = cfg_delay;
        end

        busy_d = (state_d != IDLE) || cfg_pending_d;
    end

    // State and registered outputs
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            rr_q          <= '0;
            cnt_q         <= '0;
            rd_q          <= 1'b0;
            cur_id_q      <= '0;
            cfg_pending_q <= 1'b0;
            cfg_delay_q   <= '0;
            busy_q        <= 1'b0;
            host_wvalid_q <= 1'b0;
            host_wdata_q  <= '0;
            host_addr_q   <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_id_q      <= '0;
            rsp_data_q    <= '0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            rr_q          <= rr_d;
            cnt_q         <= cnt_d;
            rd_q          <= rd_d;
            cur_id_q      <= cur_id_d;
            cfg_pending_q <= cfg_pending_d;
            cfg_delay_q   <= cfg_delay_d;
            busy_q        <= busy_d;
            host_wvalid_q <= host_wvalid_d;
            host_wdata_q  <= host_wdata_d;
            host_addr_q   <= host_addr_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_id_q      <= rsp_id_d;
            rsp_data_q    <= rsp_data_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign busy        = busy_q;
    assign host_wvalid = host_wvalid_q;
    assign host_wdata  = host_wdata_q;
    assign host_addr   = host_addr_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_id      = rsp_id_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_rx_host_sched.sv
// Directed bench for rx_host_sched with scoreboards for grants, host writes and responses.
// Latency: checks grant->wvalid 1 clock, rvalid->rsp 1 clock, timeout at issue+1025.
// Backpressure: requesters hold valid until granted.
module tb_rx_host_sched;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [3:0]  req_valid;
    logic [83:0] req_data;
    logic [3:0]  req_ready;
    logic        rsp_valid;
    logic [1:0]  rsp_id;
    logic [15:0] rsp_data;
    logic        rsp_timeout;
    logic        cfg_valid;
    logic [2:0]  cfg_delay;
    logic        busy;
    logic        host_wvalid;
    logic [20:0] host_wdata;
    logic        host_addr;
    logic [63:0] host_rdata;
    logic        host_rvalid;

    rx_host_sched #(.N_REQ(4), .FRAME(512), .READ_TIMEOUT(1024)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .rsp_valid   (rsp_valid),
        .rsp_id      (rsp_id),
        .rsp_data    (rsp_data),
        .rsp_timeout (rsp_timeout),
        .cfg_valid   (cfg_valid),
        .cfg_delay   (cfg_delay),
        .busy        (busy),
        .host_wvalid (host_wvalid),
        .host_wdata  (host_wdata),
        .host_addr   (host_addr),
        .host_rdata  (host_rdata),
        .host_rvalid (host_rvalid)
    );

    always #4 clock = ~clock;

    typedef struct { logic addr; logic [20:0] data; } wr_t;
    typedef struct { int id; logic [15:0] data; logic to; int cyc; } rsp_t;

    wr_t  exp_w[$];
    int   exp_g[$];
    rsp_t exp_r[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int gnt_cnt = 0;
    int wr_cnt = 0;
    int rsp_cnt = 0;
    int last_gnt_cyc = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Monitors: compare every grant, host write and response against the queues
    always @(negedge clock) begin : mon
        int   e;
        wr_t  w;
        rsp_t r;
        if (reset_n) begin
            if (req_ready != 4'b0) begin
                chk("gnt_onehot", 64'($onehot(req_ready)), 64'd1);
                if (exp_g.size() == 0) chk("gnt_unexp", 64'(req_ready), 64'd0);
                else begin
                    e = exp_g.pop_front();
                    chk("gnt_idx", 64'(req_ready), 64'(1 << e));
                end
                last_gnt_cyc = cyc;
                gnt_cnt++;
            end
            if (host_wvalid) begin
                wr_cnt++;
                if (exp_w.size() == 0) chk("wr_unexp", 64'd1, 64'd0);
                else begin
                    w = exp_w.pop_front();
                    chk("wr_addr", 64'(host_addr), 64'(w.addr));
                    chk("wr_data", 64'(host_wdata), 64'(w.data));
                    if (!w.addr) chk("wr_lat", 64'(cyc), 64'(last_gnt_cyc + 1));
                end
            end
            if (rsp_valid) begin
                rsp_cnt++;
                if (exp_r.size() == 0) chk("rsp_unexp", 64'd1, 64'd0);
                else begin
                    r = exp_r.pop_front();
                    chk("rsp_id", 64'(rsp_id), 64'(r.id));
                    chk("rsp_data", 64'(rsp_data), 64'(r.data));
                    chk("rsp_timeout", 64'(rsp_timeout), 64'(r.to));
                    chk("rsp_cyc", 64'(cyc), 64'(r.cyc));
                end
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) step();
    endtask

    task automatic wait_gnt(input int budget, output int t);
        int start;
        start = gnt_cnt;
        for (int k = 0; k < budget && gnt_cnt == start; k++) step();
        chk("gnt_timeout", 64'(gnt_cnt != start), 64'd1);
        t = last_gnt_cyc;
    endtask

    task automatic wait_rsp(input int budget);
        int start;
        start = rsp_cnt;
        for (int k = 0; k < budget && rsp_cnt == start; k++) step();
        chk("rsp_wait", 64'(rsp_cnt != start), 64'd1);
    endtask

    task automatic wait_idle(input int budget);
        for (int k = 0; k < budget && busy; k++) step();
        chk("idle_wait", 64'(busy), 64'd0);
    endtask

    task automatic set_req(input int i, input logic [20:0] cmd);
        req_data[i*21 +: 21] = cmd;
        req_valid[i] = 1'b1;
    endtask

    task automatic rvalid_pulse(input logic [63:0] d);
        host_rdata  = d;
        host_rvalid = 1'b1;
        step();
        host_rvalid = 1'b0;
        host_rdata  = '0;
    endtask

    task automatic chk_outs_zero(input string tag);
        chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
        chk({tag, "_rsp_id"}, 64'(rsp_id), 64'd0);
        chk({tag, "_rsp_data"}, 64'(rsp_data), 64'd0);
        chk({tag, "_rsp_to"}, 64'(rsp_timeout), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_wvalid"}, 64'(host_wvalid), 64'd0);
        chk({tag, "_wdata"}, 64'(host_wdata), 64'd0);
        chk({tag, "_waddr"}, 64'(host_addr), 64'd0);
    endtask

    initial begin
        int t, tp, t1, n;
        logic [20:0] cmd;
        reset_n     = 1'b0;
        req_valid   = '0;
        req_data    = '0;
        cfg_valid   = 1'b0;
        cfg_delay   = '0;
        host_rdata  = '0;
        host_rvalid = 1'b0;
        repeat (3) step();
        chk_outs_zero("rst");
        chk("rst_ready", 64'(req_ready), 64'd0);
        reset_n = 1'b1;

        // Idle bus: nothing happens for 2000 clocks
        repeat (2000) step();
        chk("idle_wr", 64'(wr_cnt), 64'd0);
        chk("idle_rsp", 64'(rsp_cnt), 64'd0);
        chk_outs_zero("idle");

        // All four requesters held: rr order 0,1,2,3,0, one grant per frame
        for (int i = 0; i < 4; i++) set_req(i, {1'b0, 4'(i), 16'hA000 + 16'(i)});
        for (int k = 0; k < 5; k++) begin
            exp_g.push_back(k % 4);
            exp_w.push_back('{1'b0, {1'b0, 4'(k % 4), 16'hA000 + 16'(k % 4)}});
        end
        tp = 0;
        for (int k = 0; k < 5; k++) begin
            wait_gnt(600, t);
            if (k > 0) chk("rr_gap", 64'((t - tp >= 513) && (t - tp <= 514)), 64'd1);
            tp = t;
        end
        req_valid = '0;
        chk("busy_wait_w", 64'(busy), 64'd1);

        // Single write from req0, then a read from req2 must wait out the frame
        wait_idle(600);
        exp_g.push_back(0);
        exp_w.push_back('{1'b0, 21'h03ABCD});
        set_req(0, 21'h03ABCD);
        wait_gnt(50, tp);
        req_valid = '0;
        exp_g.push_back(2);
        exp_w.push_back('{1'b0, 21'h150000});
        set_req(2, 21'h150000);
        wait_gnt(600, t);
        req_valid = '0;
        chk("wr_guard", 64'(t - tp >= 513), 64'd1);
        wait_until(t + 1 + 478);
        exp_r.push_back('{2, 16'h1234, 1'b0, cyc + 1});
        rvalid_pulse(64'hDEAD_BEEF_CAFE_1234);
        wait_rsp(10);

        // Read from req3 never answered: timeout at issue+1025, late rvalid dropped
        wait_idle(50);
        exp_g.push_back(3);
        exp_w.push_back('{1'b0, 21'h1A0000});
        set_req(3, 21'h1A0000);
        host_rdata = 64'h5555;
        wait_gnt(50, t);
        req_valid = '0;
        exp_r.push_back('{3, 16'h0000, 1'b1, t + 1 + 1025});
        wait_rsp(1100);
        host_rdata = '0;
        n = rsp_cnt;
        step();
        rvalid_pulse(64'h7777);
        repeat (20) step();
        chk("late_rsp", 64'(rsp_cnt), 64'(n));

        // rvalid on the timeout cycle: data wins
        wait_idle(50);
        exp_g.push_back(0);
        exp_w.push_back('{1'b0, 21'h1B0000});
        set_req(0, 21'h1B0000);
        wait_gnt(50, t);
        req_valid = '0;
        wait_until(t + 1 + 1024);
        exp_r.push_back('{0, 16'h0BEE, 1'b0, cyc + 1});
        rvalid_pulse(64'h0000_0000_0000_0BEE);
        wait_rsp(10);

        // Two cfg writes during a write guard with req1 waiting: one cfg write (6) first
        wait_idle(50);
        exp_g.push_back(0);
        exp_w.push_back('{1'b0, 21'h0C1111});
        set_req(0, 21'h0C1111);
        wait_gnt(50, t);
        req_valid = '0;
        wait_until(t + 100);
        cfg_delay = 3'd5;
        cfg_valid = 1'b1;
        step();
        cfg_valid = 1'b0;
        chk("busy_cfg", 64'(busy), 64'd1);
        wait_until(t + 200);
        cfg_delay = 3'd6;
        cfg_valid = 1'b1;
        step();
        cfg_valid = 1'b0;
        exp_w.push_back('{1'b1, 21'd6});
        exp_g.push_back(1);
        exp_w.push_back('{1'b0, 21'h0D2222});
        set_req(1, 21'h0D2222);
        wait_gnt(700, t1);
        req_valid = '0;
        chk("cfg_before_gnt", 64'(t1 - t >= 515), 64'd1);

        // Reset in the middle of a read: no response, in-flight rvalid dropped
        exp_g.push_back(3);
        exp_w.push_back('{1'b0, 21'h1E0000});
        set_req(3, 21'h1E0000);
        wait_gnt(700, t);
        req_valid = '0;
        wait_until(t + 300);
        n = rsp_cnt;
        reset_n = 1'b0;
        #1;
        chk_outs_zero("mid_rst");
        repeat (3) step();
        reset_n = 1'b1;
        repeat (5) step();
        rvalid_pulse(64'h4321);
        repeat (30) step();
        chk("rst_no_rsp", 64'(rsp_cnt), 64'(n));
        chk("rst_idle", 64'(busy), 64'd0);
        chk("left_g", 64'(exp_g.size()), 64'd0);
        chk("left_w", 64'(exp_w.size()), 64'd0);
        chk("left_r", 64'(exp_r.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
